// File: rtl/wb_load_queue_pkg.sv
// Shared types for the writeback load queue: request metadata and load extraction.
package wb_load_queue_pkg;

    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic       is_load;
        logic [4:0] rd_addr;
        logic [2:0] funct3;
        logic [1:0] offset;
    } wb_req_t;

    function automatic logic [31:0] extract_load(input logic [2:0]  funct3,
                                                 input logic [1:0]  offset,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[8*offset +: 8];
        h = word[16*offset[1] +: 16];
        case (load_funct3_e'(funct3))
            Lb:      res = {{24{b[7]}}, b};
            Lbu:     res = {24'h0, b};
            Lh:      res = {{16{h[15]}}, h};
            Lhu:     res = {16'h0, h};
            Lw:      res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_load_queue_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; rdata shows the head entry.
module wb_load_queue_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/wb_load_queue.sv
// In-order dmem completion queue: tracks outstanding requests, buffers early responses and
// presents extracted load data to the regfile write port.
module wb_load_queue
    import wb_load_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  wb_req_t     req_info,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    input  logic        wb_ready,
    output logic        o_wb_valid,
    output logic        o_regf_we,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_write_data,
    output logic [31:0] o_raw_rdata,
    output logic        dmem_stall,
    output logic        o_resp_err
);
    logic             meta_full, meta_empty, data_empty, data_full_unused;
    wb_req_t          head;
    logic [31:0]      data_head, raw;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             err_q;
    logic             accept, legit_resp, head_ret, bypass, complete, data_push, data_pop;

    assign req_ready = !meta_full;
    assign accept    = req_valid & req_ready;

    // pend_q counts accepted requests whose response has not arrived yet
    assign legit_resp = dmem_resp & (pend_q != '0);
    assign head_ret   = !data_empty;
    assign bypass     = legit_resp & data_empty;
    assign o_wb_valid = head_ret | bypass;
    assign complete   = o_wb_valid & wb_ready;
    assign data_push  = legit_resp & !(bypass & wb_ready);
    assign data_pop   = complete & head_ret;

    always_comb begin
        pend_d = pend_q;
        case ({accept, legit_resp})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_q | (dmem_resp & !legit_resp);
        end
    end

    wb_load_queue_sync_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (DEPTH)
    ) u_meta_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (complete),
        .wdata (req_info),
        .rdata (head),
        .full  (meta_full),
        .empty (meta_empty)
    );

    wb_load_queue_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_push),
        .pop   (data_pop),
        .wdata (dmem_rdata),
        .rdata (data_head),
        .full  (data_full_unused),
        .empty (data_empty)
    );

    assign raw = head_ret ? data_head : dmem_rdata;

    // Outputs are gated so FIFO storage contents never leak out when nothing is presented
    always_comb begin
        o_rd_addr    = '0;
        o_raw_rdata  = '0;
        o_write_data = '0;
        o_regf_we    = 1'b0;
        if (o_wb_valid) begin
            o_rd_addr   = head.rd_addr;
            o_raw_rdata = raw;
            o_regf_we   = head.is_load & (head.rd_addr != 5'd0);
            if (head.is_load) o_write_data = extract_load(head.funct3, head.offset, raw);
        end
    end

    assign dmem_stall = !meta_empty & data_empty & !dmem_resp;
    assign o_resp_err = err_q;

endmodule

// File: tb/tb_wb_load_queue.sv
// Randomized scoreboard bench for wb_load_queue against a queue-based reference model.
module tb_wb_load_queue;
    import wb_load_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, dmem_resp, wb_ready;
    wb_req_t     req_info;
    logic [31:0] dmem_rdata;
    logic        o_wb_valid, o_regf_we, dmem_stall, o_resp_err;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_write_data, o_raw_rdata;

    always #5 clk = ~clk;

    wb_load_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_info     (req_info),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .wb_ready     (wb_ready),
        .o_wb_valid   (o_wb_valid),
        .o_regf_we    (o_regf_we),
        .o_rd_addr    (o_rd_addr),
        .o_write_data (o_write_data),
        .o_raw_rdata  (o_raw_rdata),
        .dmem_stall   (dmem_stall),
        .o_resp_err   (o_resp_err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] raw;
    } exp_t;

    exp_t    sb[$];
    wb_req_t m_info[$];   // accepted, not completed; first m_nret of them have responded
    int      m_nret;
    bit      m_err;
    int      total = 0;
    int      bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wb_req_t mk(input logic l, input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [1:0] off);
        wb_req_t r;
        r.is_load = l;
        r.rd_addr = rd;
        r.funct3  = f3;
        r.offset  = off;
        return r;
    endfunction

    function automatic logic [31:0] model_data(input wb_req_t r, input logic [31:0] w);
        logic [31:0] v;
        if (!r.is_load) return 32'h0;
        case (r.funct3)
            3'd0, 3'd4: begin
                v = (w >> (8 * r.offset)) & 32'hFF;
                if (r.funct3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * r.offset[1])) & 32'hFFFF;
                if (r.funct3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            3'd2:    v = w;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // One cycle: drive inputs, check handshake outputs against the model, then advance the model.
    task automatic step(input logic v, input wb_req_t info, input logic resp,
                        input logic [31:0] rdata, input logic wr);
        bit   head_ret, legit, exp_valid, exp_ready, exp_stall;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = v;
        req_info   = info;
        dmem_resp  = resp;
        dmem_rdata = rdata;
        wb_ready   = wr;
        #1;
        head_ret  = (m_nret > 0);
        legit     = resp && (m_info.size() > m_nret);
        exp_valid = head_ret || (legit && m_nret == 0);
        exp_ready = (m_info.size() < DEPTH);
        exp_stall = (m_info.size() > 0) && !head_ret && !resp;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("wb_valid", 32'(o_wb_valid), 32'(exp_valid));
        chk("dmem_stall", 32'(dmem_stall), 32'(exp_stall));
        chk("resp_err", 32'(o_resp_err), 32'(m_err));
        if (legit) begin
            e.we   = m_info[m_nret].is_load && (m_info[m_nret].rd_addr != 0);
            e.rd   = m_info[m_nret].rd_addr;
            e.data = model_data(m_info[m_nret], rdata);
            e.raw  = rdata;
            sb.push_back(e);
            m_nret++;
        end
        if (resp && !legit) m_err = 1'b1;
        if (exp_valid && wr) begin
            void'(m_info.pop_front());
            m_nret--;
        end
        if (v && exp_ready) m_info.push_back(info);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 0; req_info = '0; dmem_resp = 0; dmem_rdata = '0; wb_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_regf_we", 32'(o_regf_we), 32'd0);
        chk("rst_dmem_stall", 32'(dmem_stall), 32'd0);
        chk("rst_resp_err", 32'(o_resp_err), 32'd0);
        chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
        chk("rst_write_data", o_write_data, 32'd0);
        chk("rst_raw_rdata", o_raw_rdata, 32'd0);
        m_info.delete();
        sb.delete();
        m_nret = 0;
        m_err  = 1'b0;
        rst = 1'b0;
    endtask

    // Monitor: every completion must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=valid rd=%0d required=no completion",
                         o_rd_addr);
            end else begin
                e = sb.pop_front();
                chk("regf_we", 32'(o_regf_we), 32'(e.we));
                chk("rd_addr", 32'(o_rd_addr), 32'(e.rd));
                chk("write_data", o_write_data, e.data);
                chk("raw_rdata", o_raw_rdata, e.raw);
            end
        end
    end

    function automatic wb_req_t rand_req();
        logic [2:0] f3;
        case ($urandom_range(0, 5))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            4: f3 = 3'd5;
            default: f3 = 3'd3;
        endcase
        return mk(($urandom_range(0, 3) != 0), 5'($urandom), f3, 2'($urandom));
    endfunction

    initial begin
        rst = 1'b1;
        req_valid = 0; req_info = '0; dmem_resp = 0; dmem_rdata = '0; wb_ready = 0;
        m_nret = 0;
        m_err  = 1'b0;
        reset_dut();

        // Single signed byte load with same-cycle bypass
        step(1, mk(1, 5'd5, Lb, 2'd3), 0, 32'h0, 1);
        step(0, '0, 1, 32'h8000_0000, 1);

        // Four loads fill the queue, responses held back by writeback stall
        step(1, mk(1, 5'd1, Lhu, 2'd2), 0, 32'h0, 0);
        step(1, mk(1, 5'd2, Lw, 2'd0), 0, 32'h0, 0);
        step(1, mk(1, 5'd3, Lb, 2'd1), 0, 32'h0, 0);
        step(1, mk(1, 5'd4, Lbu, 2'd0), 0, 32'h0, 0);
        step(1, mk(1, 5'd9, Lw, 2'd0), 0, 32'h0, 0);
        step(0, '0, 1, 32'hF00D_1234, 0);
        step(0, '0, 1, 32'hCAFE_BABE, 0);
        step(0, '0, 1, 32'h0000_8000, 0);
        step(0, '0, 1, 32'h1234_56F0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 0, 32'h0, 1);

        // Store then load to x0: neither writes the regfile
        step(1, mk(0, 5'd7, 3'd2, 2'd0), 0, 32'h0, 1);
        step(1, mk(1, 5'd0, Lw, 2'd0), 1, 32'h1111_2222, 1);
        step(0, '0, 1, 32'h3333_4444, 1);
        step(0, '0, 0, 32'h0, 1);

        // Orphan response sets the sticky error
        step(0, '0, 1, 32'hDEAD_BEEF, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 32'h0, 1);
        reset_dut();

        // Accept, respond and complete in one cycle at occupancy 2
        step(1, mk(1, 5'd10, Lw, 2'd0), 0, 32'h0, 0);
        step(1, mk(1, 5'd11, Lh, 2'd2), 0, 32'h0, 0);
        step(0, '0, 1, 32'hAAAA_0001, 0);
        step(1, mk(1, 5'd12, Lbu, 2'd3), 1, 32'h8001_0002, 1);
        step(0, '0, 0, 32'h0, 0);
        step(0, '0, 1, 32'h9900_0000, 1);
        step(0, '0, 0, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic do_resp;
            do_resp = (m_info.size() > m_nret) && ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 2) != 0), rand_req(), do_resp, $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        // Drain with bounded effort
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            if (m_info.size() > 0) step(0, '0, (m_info.size() > m_nret), $urandom, 1);
        end
        step(0, '0, 0, 32'h0, 1);
        chk("model_drained", 32'(m_info.size()), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
